// File: rtl/tdc_hit_readout.sv
// Read-side buffer for TDC encoder hits: TOA window filter, event tagging,
// small FIFO with a registered valid/ready output and drop accounting.
module tdc_hit_readout #(
    parameter int FIFO_DEPTH = 4,
    parameter int TOA_W      = 10,
    parameter int TOT_W      = 9,
    parameter int CAL_W      = 10,
    parameter int EVT_W      = 3
) (
    input  logic                                 clk40,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 encStrobe,
    input  logic                                 hitFlag,
    input  logic [TOA_W-1:0]                     TOA_code,
    input  logic [TOT_W-1:0]                     TOT_code,
    input  logic [CAL_W-1:0]                     Cal_code,
    input  logic [TOA_W-1:0]                     toaLow,
    input  logic [TOA_W-1:0]                     toaHigh,
    output logic [EVT_W+TOA_W+TOT_W+CAL_W-1:0]   dout,
    output logic                                 dvalid,
    input  logic                                 dready,
    output logic [$clog2(FIFO_DEPTH):0]          occupancy,
    output logic                                 overflow,
    output logic [7:0]                           dropCnt
);

    localparam int DW    = EVT_W + TOA_W + TOT_W + CAL_W;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PW + 1;

    localparam logic [PW-1:0]    PTR_ONE = PW'(1);
    localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);
    localparam logic [EVT_W-1:0] EVT_ONE = EVT_W'(1);

    logic [DW-1:0]    mem_q [FIFO_DEPTH];
    logic [DW-1:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic [DW-1:0]    dout_q, dout_d;
    logic             dvalid_q, dvalid_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic             pop_s;
    logic             event_s;
    logic             qualify_s;
    logic             push_s;
    logic             drop_s;
    logic [DW-1:0]    new_word_s;
    logic [DW-1:0]    head_s;

    // Handshake decode, hit qualification and next-state computation
    always_comb begin
        pop_s      = dvalid_q & dready;
        event_s    = enable & encStrobe;
        qualify_s  = event_s & hitFlag & (TOA_code >= toaLow) & (TOA_code <= toaHigh);
        push_s     = qualify_s & ((occ_q < DEPTH_C) | pop_s);
        drop_s     = qualify_s & ~push_s;
        new_word_s = {evt_q, TOA_code, TOT_code, Cal_code};

        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = new_word_s;
        end else begin
            mem_d = mem_q;
        end

        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase

        // The new head is the word being written when the buffer would otherwise be empty
        if (push_s && (rd_ptr_d == wr_ptr_q)) begin
            head_s = new_word_s;
        end else begin
            head_s = mem_q[rd_ptr_d];
        end

        dvalid_d = (occ_d != {OCC_W{1'b0}});
        dout_d   = dvalid_d ? head_s : {DW{1'b0}};

        evt_d      = event_s ? (evt_q + EVT_ONE) : evt_q;
        overflow_d = overflow_q | drop_s;
        if (drop_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk40 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            occ_q      <= {OCC_W{1'b0}};
            evt_q      <= {EVT_W{1'b0}};
            dout_q     <= {DW{1'b0}};
            dvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            evt_q      <= evt_d;
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign dout      = dout_q;
    assign dvalid    = dvalid_q;
    assign occupancy = occ_q;
    assign overflow  = overflow_q;
    assign dropCnt   = drop_cnt_q;

endmodule
